// File: rtl/cjb_param_hw_stack_v.sv
// ---------------------------------------------------------------------------
// cjb_param_hw_stack_v
//
// Parameterised hardware LIFO stack held in a DEPTH x N register array.
// Entries live in a circular window that starts at the base pointer bp (the
// oldest entry) and spans count locations. The top of stack (TOS) therefore
// sits at (bp + count - 1) mod DEPTH.
//
// With WRAP = 0 the stack saturates: a push into a full stack is dropped.
// With WRAP = 1 the stack is circular: a push into a full stack overwrites
// the oldest entry and advances bp.
//
// Ports
//   Clock    in   single clock, all state updates on the rising edge
//   Reset    in   synchronous active-high reset, overrides every other input
//   push     in   push Din this cycle
//   pop      in   pop the TOS this cycle
//   clr_err  in   clear the sticky ovf/unf flags (a same-cycle set wins)
//   Din      in   N-bit data to push
//   Dout     out  N-bit TOS, combinational from stored state, 0 when empty
//   count    out  AW+1-bit number of valid entries, 0..DEPTH
//   empty    out  count == 0
//   full     out  count == DEPTH
//   ovf      out  sticky overflow flag (push while full)
//   unf      out  sticky underflow flag (pop-only while empty)
//
// Handshake: there is no ready/valid back-pressure. push and pop are
// single-cycle commands sampled at the rising edge. Dout always shows the
// current TOS, so a consumer samples Dout in the same cycle it raises pop;
// the entry is discarded at that edge. push+pop together replaces the TOS
// (or acts as a plain push when the stack is empty).
// ---------------------------------------------------------------------------
module cjb_param_hw_stack_v #(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int WRAP  = 0,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    input  logic [N-1:0]  Din,
    output logic [N-1:0]  Dout,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
);

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic [AW-1:0] bp_q, bp_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          is_empty;
    logic          is_full;
    logic          ovf_set;
    logic          unf_set;
    logic [AW-1:0] tos_idx;
    logic [AW-1:0] push_idx;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == (AW+1)'(DEPTH));

    // Only the low AW bits of count matter modulo DEPTH. When the stack is
    // full they are zero, so push_idx lands on bp, which is exactly the
    // oldest slot a circular push must overwrite.
    assign tos_idx  = bp_q + count_q[AW-1:0] - AW'(1);
    assign push_idx = bp_q + count_q[AW-1:0];

    always_comb begin
        mem_d   = mem_q;
        bp_d    = bp_q;
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (push && pop && !is_empty) begin
            // Replace TOS in place; depth and flags are untouched.
            mem_d[tos_idx] = Din;
        end else if (push) begin
            // Also covers push+pop on an empty stack.
            if (!is_full) begin
                mem_d[push_idx] = Din;
                count_d         = count_q + (AW+1)'(1);
            end else begin
                ovf_set = 1'b1;
                if (WRAP != 0) begin
                    mem_d[push_idx] = Din;
                    bp_d            = bp_q + AW'(1);
                end
            end
        end else if (pop) begin
            if (!is_empty) begin
                count_d = count_q - (AW+1)'(1);
            end else begin
                unf_set = 1'b1;
            end
        end

        // Set-priority sticky flags.
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        unf_d = unf_set | (unf_q & ~clr_err);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            bp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            bp_q    <= bp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately not reset; stale words are hidden behind count.
    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

    assign Dout  = is_empty ? '0 : mem_q[tos_idx];
    assign count = count_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_cjb_param_hw_stack_v.sv
module tb_cjb_param_hw_stack_v;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    // ---------------- DUT instances ----------------
    // 0: N=8 DEPTH=4 WRAP=0   1: N=8 DEPTH=4 WRAP=1   2: N=16 DEPTH=8 WRAP=0
    logic        push_i [3];
    logic        pop_i  [3];
    logic        clr_i  [3];
    logic [15:0] din_i  [3];

    logic [7:0]  dout_a, dout_b;
    logic [15:0] dout_c;
    logic [2:0]  count_a, count_b;
    logic [3:0]  count_c;
    logic        empty_a, full_a, ovf_a, unf_a;
    logic        empty_b, full_b, ovf_b, unf_b;
    logic        empty_c, full_c, ovf_c, unf_c;

    cjb_param_hw_stack_v #(.N(8), .DEPTH(4), .WRAP(0)) u_a (
        .Clock(Clock), .Reset(Reset), .push(push_i[0]), .pop(pop_i[0]),
        .clr_err(clr_i[0]), .Din(din_i[0][7:0]), .Dout(dout_a), .count(count_a),
        .empty(empty_a), .full(full_a), .ovf(ovf_a), .unf(unf_a)
    );

    cjb_param_hw_stack_v #(.N(8), .DEPTH(4), .WRAP(1)) u_b (
        .Clock(Clock), .Reset(Reset), .push(push_i[1]), .pop(pop_i[1]),
        .clr_err(clr_i[1]), .Din(din_i[1][7:0]), .Dout(dout_b), .count(count_b),
        .empty(empty_b), .full(full_b), .ovf(ovf_b), .unf(unf_b)
    );

    cjb_param_hw_stack_v #(.N(16), .DEPTH(8), .WRAP(0)) u_c (
        .Clock(Clock), .Reset(Reset), .push(push_i[2]), .pop(pop_i[2]),
        .clr_err(clr_i[2]), .Din(din_i[2]), .Dout(dout_c), .count(count_c),
        .empty(empty_c), .full(full_c), .ovf(ovf_c), .unf(unf_c)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] dout;
        logic [3:0]  cnt;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    sel    = 0;

    function automatic exp_t observe(input logic [1:0] s);
        exp_t o;
        o.sel = s;
        case (s)
            2'd0:    begin o.dout = {8'h00, dout_a}; o.cnt = {1'b0, count_a};
                           o.empty = empty_a; o.full = full_a; o.ovf = ovf_a; o.unf = unf_a; end
            2'd1:    begin o.dout = {8'h00, dout_b}; o.cnt = {1'b0, count_b};
                           o.empty = empty_b; o.full = full_b; o.ovf = ovf_b; o.unf = unf_b; end
            default: begin o.dout = dout_c; o.cnt = count_c;
                           o.empty = empty_c; o.full = full_c; o.ovf = ovf_c; o.unf = unf_c; end
        endcase
        return o;
    endfunction

    // Monitor: outputs are state-only, so every queued expectation is
    // compared on the falling edge of the cycle it was issued in.
    always @(negedge Clock) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  o;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            o  = observe(e.sel);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s (dut%0d): got dout=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b, expected dout=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b",
                         nm, e.sel, o.dout, o.cnt, o.empty, o.full, o.ovf, o.unf,
                         e.dout, e.cnt, e.empty, e.full, e.ovf, e.unf);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic rst, input logic p, input logic q,
                       input logic c, input logic [15:0] d);
        for (int i = 0; i < 3; i++) begin
            push_i[i] = 1'b0; pop_i[i] = 1'b0; clr_i[i] = 1'b0; din_i[i] = 16'h0;
        end
        Reset       = rst;
        push_i[sel] = p;
        pop_i[sel]  = q;
        clr_i[sel]  = c;
        din_i[sel]  = d;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    task automatic do_push(input logic [15:0] d);  cyc(1'b0, 1'b1, 1'b0, 1'b0, d);     endtask
    task automatic do_pop();                       cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0); endtask
    task automatic do_pp(input logic [15:0] d);    cyc(1'b0, 1'b1, 1'b1, 1'b0, d);     endtask
    task automatic do_clr();                       cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0); endtask
    task automatic do_rst();                       cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0); endtask

    // Expected outputs for the current cycle (state after the last edge).
    task automatic ex(input logic [15:0] d, input int c, input logic e, input logic f,
                      input logic o, input logic u, input string nm);
        exp_t x;
        x.sel = 2'(sel); x.dout = d; x.cnt = 4'(c);
        x.empty = e; x.full = f; x.ovf = o; x.unf = u;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            push_i[i] = 1'b0; pop_i[i] = 1'b0; clr_i[i] = 1'b0; din_i[i] = 16'h0;
        end

        // ===== DUT 0: DEPTH=4, saturating =====
        sel = 0;
        do_rst();
        ex(16'h00, 0, 1, 0, 0, 0, "reset");

        do_push(16'h11); do_push(16'h22); do_push(16'h33);
        ex(16'h33, 3, 0, 0, 0, 0, "push3");
        do_pop();
        ex(16'h22, 2, 0, 0, 0, 0, "pop1");
        do_pop();
        ex(16'h11, 1, 0, 0, 0, 0, "pop2");
        do_pop();
        ex(16'h00, 0, 1, 0, 0, 0, "pop3_empty");

        do_push(16'h01); do_push(16'h02); do_push(16'h03); do_push(16'h04);
        ex(16'h04, 4, 0, 1, 0, 0, "fill4");
        do_push(16'h05);
        ex(16'h04, 4, 0, 1, 1, 0, "sat_ovf");
        do_clr();
        ex(16'h04, 4, 0, 1, 0, 0, "clr_ovf");

        do_pp(16'h77);
        ex(16'h77, 4, 0, 1, 0, 0, "full_pushpop");
        do_pop();
        ex(16'h03, 3, 0, 0, 0, 0, "after_replace_pop");
        do_pop(); do_pop(); do_pop();
        ex(16'h00, 0, 1, 0, 0, 0, "drain");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);    // underflow pop with clr_err
        ex(16'h00, 0, 1, 0, 0, 1, "unf_beats_clr");
        do_clr();
        ex(16'h00, 0, 1, 0, 0, 0, "clr_unf");

        do_pp(16'hAA);
        ex(16'hAA, 1, 0, 0, 0, 0, "empty_pushpop");
        do_pp(16'hBB);
        ex(16'hBB, 1, 0, 0, 0, 0, "replace_single");
        do_pop();
        ex(16'h00, 0, 1, 0, 0, 0, "pop_to_empty");
        do_pop();
        ex(16'h00, 0, 1, 0, 0, 1, "underflow");

        // unf is still set here; a mid-sequence reset must clear it
        do_push(16'h10); do_push(16'h20);
        ex(16'h20, 2, 0, 0, 0, 1, "pre_reset");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h99);  // reset wins over push
        ex(16'h00, 0, 1, 0, 0, 0, "reset_mid");
        do_push(16'h30);
        ex(16'h30, 1, 0, 0, 0, 0, "push_after_reset");

        // ===== DUT 1: DEPTH=4, circular =====
        sel = 1;
        do_rst();
        ex(16'h00, 0, 1, 0, 0, 0, "reset_wrap");
        for (int i = 1; i <= 6; i++) do_push(16'(i));
        ex(16'h06, 4, 0, 1, 1, 0, "wrap_push6");
        do_pop();
        ex(16'h05, 3, 0, 0, 1, 0, "wrap_pop1");
        do_pop();
        ex(16'h04, 2, 0, 0, 1, 0, "wrap_pop2");
        do_pop();
        ex(16'h03, 1, 0, 0, 1, 0, "wrap_pop3");
        do_pop();
        ex(16'h00, 0, 1, 0, 1, 0, "wrap_empty");

        // ===== DUT 2: N=16, DEPTH=8 =====
        sel = 2;
        do_rst();
        ex(16'h0000, 0, 1, 0, 0, 0, "reset_wide");
        do_push(16'h1111); do_push(16'h2222); do_push(16'h3333);
        ex(16'h3333, 3, 0, 0, 0, 0, "wide_push3");
        do_pop();
        ex(16'h2222, 2, 0, 0, 0, 0, "wide_pop1");
        do_pop();
        ex(16'h1111, 1, 0, 0, 0, 0, "wide_pop2");
        do_pop();
        ex(16'h0000, 0, 1, 0, 0, 0, "wide_empty");
        for (int i = 1; i <= 8; i++) do_push(16'(i * 16'h0101));
        ex(16'h0808, 8, 0, 1, 0, 0, "wide_full");
        do_push(16'h0909);
        ex(16'h0808, 8, 0, 1, 1, 0, "wide_ovf");

        // let the monitor drain, bounded
        repeat (3) @(posedge Clock);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
